// File: rtl/bcd_to_ex3.sv
// rtl/bcd_to_ex3.sv - registered BCD to Excess-3 converter with valid qualifier and error detection
module bcd_to_ex3 #(
    parameter int PIPE_STAGES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    input  logic err_clr,
    output logic W,
    output logic X,
    output logic Y,
    output logic Z,
    output logic out_valid,
    output logic err,
    output logic err_sticky
);

    generate
        if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_pipe_stages
            $error("bcd_to_ex3: PIPE_STAGES must be in 1..4");
        end
    endgenerate

    logic [3:0] digit;
    logic       legal;
    logic       s0_valid;
    logic [3:0] s0_code;
    logic       s0_err;

    logic       vld_q  [PIPE_STAGES];
    logic [3:0] code_q [PIPE_STAGES];
    logic       err_q  [PIPE_STAGES];

    assign digit = {A, B, C, D};
    assign legal = (digit <= 4'd9);

    // Convert the incoming digit; bubbles and illegal codes carry an all-zero code word
    always_comb begin
        s0_valid = in_valid;
        s0_code  = 4'd0;
        s0_err   = 1'b0;
        if (in_valid) begin
            if (legal) begin
                s0_code = digit + 4'd3;
            end else begin
                s0_err = 1'b1;
            end
        end
    end

    // Pipeline shift register; reset flushes every stage so in-flight digits are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                vld_q[i]  <= 1'b0;
                code_q[i] <= 4'd0;
                err_q[i]  <= 1'b0;
            end
        end else begin
            vld_q[0]  <= s0_valid;
            code_q[0] <= s0_code;
            err_q[0]  <= s0_err;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                vld_q[i]  <= vld_q[i-1];
                code_q[i] <= code_q[i-1];
                err_q[i]  <= err_q[i-1];
            end
        end
    end

    assign {W, X, Y, Z} = code_q[PIPE_STAGES-1];
    assign out_valid    = vld_q[PIPE_STAGES-1];
    assign err          = err_q[PIPE_STAGES-1];

    // Sticky error flag: a new error result wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else begin
            err_sticky <= (err_clr ? 1'b0 : err_sticky) | (out_valid & err);
        end
    end

endmodule

// File: tb/tb_bcd_to_ex3.sv
// tb/tb_bcd_to_ex3.sv - directed self-checking bench for bcd_to_ex3 with a 3-stage pipeline
module tb_bcd_to_ex3;

    localparam int PIPE = 3;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic A, B, C, D;
    logic err_clr;
    logic W, X, Y, Z;
    logic out_valid;
    logic err;
    logic err_sticky;

    int errors = 0;
    int checks = 0;

    logic [3:0] ex3_tab [10] = '{4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                                 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100};

    bcd_to_ex3 #(.PIPE_STAGES(PIPE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .err_clr   (err_clr),
        .W         (W),
        .X         (X),
        .Y         (Y),
        .Z         (Z),
        .out_valid (out_valid),
        .err       (err),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    // Apply inputs, advance one rising edge, settle 1 time unit past it
    task automatic step(input logic r, input logic v, input logic [3:0] d, input logic clr);
        rst      = r;
        in_valid = v;
        {A, B, C, D} = d;
        err_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] exp_code, input logic exp_v,
                         input logic exp_e, input logic exp_s);
        logic [3:0] obs;
        obs = {W, X, Y, Z};
        checks++;
        assert (obs === exp_code) else begin
            errors++;
            $error("FAIL %s code observed=%b expected=%b", tag, obs, exp_code);
        end
        checks++;
        assert (out_valid === exp_v) else begin
            errors++;
            $error("FAIL %s out_valid observed=%b expected=%b", tag, out_valid, exp_v);
        end
        checks++;
        assert (err === exp_e) else begin
            errors++;
            $error("FAIL %s err observed=%b expected=%b", tag, err, exp_e);
        end
        checks++;
        assert (err_sticky === exp_s) else begin
            errors++;
            $error("FAIL %s err_sticky observed=%b expected=%b", tag, err_sticky, exp_s);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; {A, B, C, D} = 4'b0000; err_clr = 1'b0;

        // Reset held two cycles with a valid digit on the inputs
        step(1'b1, 1'b1, 4'b0101, 1'b0); check("reset_1", 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'b0101, 1'b0); check("reset_2", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Sweep 0..9 back-to-back; result of digit k appears after edge k+2
        for (int i = 0; i < 12; i++) begin
            step(1'b0, (i < 10), 4'(i), 1'b0);
            if (i < PIPE - 1) check($sformatf("sweep_lat_%0d", i), 4'b0000, 1'b0, 1'b0, 1'b0);
            else              check($sformatf("sweep_d%0d", i - 2), ex3_tab[i-2], 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 4'b0000, 1'b0); check("sweep_tail", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Illegal codes followed by a legal zero
        step(1'b0, 1'b1, 4'b1010, 1'b0); check("ill_a", 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'b1111, 1'b0); check("ill_b", 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'b0000, 1'b0); check("ill_1010", 4'b0000, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 1'b0); check("ill_1111", 4'b0000, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 4'b0000, 1'b0); check("ill_then_0", 4'b0011, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'b0000, 1'b0); check("ill_hold", 4'b0000, 1'b0, 1'b0, 1'b1);

        // Sticky clear, then clear coinciding with a new error result
        step(1'b0, 1'b0, 4'b0000, 1'b1); check("clr", 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'b1100, 1'b0); check("clr_in", 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 1'b0); check("clr_wait", 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 1'b0); check("clr_err_out", 4'b0000, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 1'b1); check("clr_set_wins", 4'b0000, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'b0000, 1'b0); check("clr_hold", 4'b0000, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'b0000, 1'b1); check("clr_again", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Bubbles: 7, invalid slot carrying illegal data, 2
        step(1'b0, 1'b1, 4'b0111, 1'b0); check("bub_a", 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b1111, 1'b0); check("bub_b", 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'b0010, 1'b0); check("bub_7", 4'b1010, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b0101, 1'b0); check("bub_gap", 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 1'b0); check("bub_2", 4'b0101, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 1'b0); check("bub_tail", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Reset mid-stream with 8 in flight and an error result at the output
        step(1'b0, 1'b1, 4'b1111, 1'b0); check("mid_a", 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'b1000, 1'b0); check("mid_b", 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 1'b0); check("mid_err", 4'b0000, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4'b0000, 1'b0); check("mid_rst", 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'b0100, 1'b0); check("mid_no8_a", 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 1'b0); check("mid_no8_b", 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 1'b0); check("mid_first_4", 4'b0111, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 1'b0); check("mid_tail", 4'b0000, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
